// File: rtl/minicore_pkg.sv
// MiniCore shared datapath types.
// Op encodings and the adder flag bundle.
package minicore_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic neg;
  } flags_t;

endpackage

// File: rtl/adder_seg.sv
// One carry-chain segment of the pipelined adder.
// Pure combinational: sum, carry out and segment-zero.
module adder_seg #(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_zero
);

  logic [SEG:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b}
                + {{SEG{1'b0}}, i_cin};
  assign o_sum  = w_full[SEG-1:0];
  assign o_cout = w_full[SEG];
  assign o_zero = ~|w_full[SEG-1:0];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/sub unit: carry chain split into
// STAGES segments, valid/ready with full backpressure.
module pipelined_adder
  import minicore_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int SEG = WIDTH / STAGES;
  localparam int LST = STAGES - 1;

  logic             w_adv;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;
  flags_t           w_fl;

  always_comb begin
    w_beff = in_b;
    w_c0   = 1'b0;
    unique case (op_e'(in_op))
      OP_ADD: w_c0 = 1'b0;
      OP_SUB: begin
        w_beff = ~in_b;
        w_c0   = 1'b1;
      end
      OP_ADC: w_c0 = in_cin;
      OP_SBC: begin
        w_beff = ~in_b;
        w_c0   = in_cin;
      end
    endcase
  end

  // Stage k consumes the low SEG bits of its operand
  // and forwards only the still-unprocessed high bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int IW = WIDTH - k * SEG;
    localparam int DW = (k + 1) * SEG;

    logic [IW-1:0]  w_a;
    logic [IW-1:0]  w_b;
    logic           w_ci;
    logic           w_zi;
    logic           w_vi;
    logic [SEG-1:0] w_sum;
    logic           w_co;
    logic           w_zs;
    logic [DW-1:0]  w_d;
    logic [DW-1:0]  r_s;
    logic           r_c;
    logic           r_z;
    logic           r_v;

    if (k == 0) begin : g_in
      assign w_a  = in_a;
      assign w_b  = w_beff;
      assign w_ci = w_c0;
      assign w_zi = 1'b1;
      assign w_vi = in_valid & w_adv;
      assign w_d  = w_sum;
    end else begin : g_in
      assign w_a  = g_st[k-1].g_keep.r_a;
      assign w_b  = g_st[k-1].g_keep.r_b;
      assign w_ci = g_st[k-1].r_c;
      assign w_zi = g_st[k-1].r_z;
      assign w_vi = g_st[k-1].r_v;
      assign w_d  = {w_sum, g_st[k-1].r_s};
    end

    adder_seg #(.SEG(SEG)) u_seg (
      .i_a    (w_a[SEG-1:0]),
      .i_b    (w_b[SEG-1:0]),
      .i_cin  (w_ci),
      .o_sum  (w_sum),
      .o_cout (w_co),
      .o_zero (w_zs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_s <= '0;
        r_c <= 1'b0;
        r_z <= 1'b0;
      end else if (w_adv) begin
        r_v <= w_vi;
        if (w_vi) begin
          r_s <= w_d;
          r_c <= w_co;
          r_z <= w_zi & w_zs;
        end
      end
    end

    if (k < LST) begin : g_keep
      logic [IW-SEG-1:0] r_a;
      logic [IW-SEG-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_vi) begin
          r_a <= w_a[IW-1:SEG];
          r_b <= w_b[IW-1:SEG];
        end
      end
    end else begin : g_sign
      logic r_am;
      logic r_bm;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_am <= 1'b0;
          r_bm <= 1'b0;
        end else if (w_adv && w_vi) begin
          r_am <= w_a[IW-1];
          r_bm <= w_b[IW-1];
        end
      end
    end
  end

  assign out_valid = g_st[LST].r_v;
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_sum   = g_st[LST].r_s;

  always_comb begin
    w_fl.carry = g_st[LST].r_c;
    w_fl.ovf   = (g_st[LST].g_sign.r_am
                  == g_st[LST].g_sign.r_bm)
               & (out_sum[WIDTH-1]
                  != g_st[LST].g_sign.r_am);
    w_fl.zero  = g_st[LST].r_z;
    w_fl.neg   = out_sum[WIDTH-1];
  end

  assign out_carry = w_fl.carry;
  assign out_ovf   = w_fl.ovf;
  assign out_zero  = w_fl.zero;
  assign out_neg   = w_fl.neg;

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined integer add/subtract unit for the MiniCore datapath. It is the successor to the single-cycle 32-bit combinational adder.
- The carry chain is split into STAGES equal segments, one register stage per segment. This shortens the critical path for wide operands.
- Supports ADD, SUB, add-with-carry and subtract-with-carry. Produces carry, signed-overflow, zero and negative flags.
- Uses a valid/ready handshake with full backpressure, so it can sit between the decode/issue logic and writeback.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline stages (carry-chain segments), 1..8; latency in cycles.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- in_cin  input  1  carry-in, used only by ADC/SBC.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result this cycle.
- out_sum  output  WIDTH  result.
- out_carry  output  1  carry out of the MSB (for SUB/SBC: 1 = no borrow).
- out_ovf  output  1  signed two's-complement overflow.
- out_zero  output  1  out_sum == 0.
- out_neg  output  1  out_sum[WIDTH-1].

Behaviour:
- Reset: the clock is clk; reset is rst_n, asynchronous, active-low. While rst_n=0, all stage valid bits clear, out_valid=0, and out_sum/out_carry/out_ovf/out_zero/out_neg=0. in_ready=1 after reset.
- Operand conditioning (combinational at input):
  - b_eff = in_b for ADD/ADC, ~in_b for SUB/SBC.
  - c0 = 0 for ADD, 1 for SUB, in_cin for ADC/SBC.
- Segmentation: SEG = WIDTH/STAGES. Stage k (0..STAGES-1) computes bits [k*SEG +: SEG] as a_seg + b_seg + carry from stage k-1 (stage 0 uses c0).
- Registered per stage: completed low bits, remaining unprocessed high operand bits, running carry, running zero (AND of segment-zero terms), sign bits of A and b_eff, and valid.
- Latency: exactly STAGES cycles from handshake (in_valid & in_ready) to out_valid, assuming no stall.
- Flags (final stage):
  - out_carry = carry out of bit WIDTH-1.
  - out_ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb).
  - out_zero = running zero; out_neg = sum MSB.
- Advance rule: advance = !out_valid | out_ready. On advance, every stage shifts forward by one. On !advance, all stages hold and in_ready=0.
  - in_ready = advance (combinational from out_valid/out_ready; no combinational path from in_valid).
- Throughput: one operation per cycle when out_ready is held high. Bubbles (in_valid=0) propagate as invalid stages.
- Output stability: while out_valid=1 and out_ready=0, out_sum and all flags hold stable.
- Data capture: stage data registers load only when the incoming valid is 1. Invalid slots keep stale data; outputs are don't-care while out_valid=0.
- STAGES=1: degenerates to a registered single-cycle adder with latency 1.
- Wrap-around: the sum is modulo 2^WIDTH; no saturation.
- Reset mid-operation: all in-flight operations are discarded; nothing is emitted after reset release.
- Simultaneous in-handshake and out-handshake in one cycle: both complete and the pipeline stays full.

Decomposition:
- Shared package minicore_pkg:
  - op encodings OP_ADD/OP_SUB/OP_ADC/OP_SBC (2 bits).
  - flag bundle typedef {carry, ovf, zero, neg}.
- One sub-module adder_seg: SEG-wide combinational segment (a, b, cin -> sum, cout, zero). Instantiated once per stage via a generate loop.
- Pipeline registers and handshake live in pipelined_adder.

Test Plan (WIDTH=32, STAGES=2 unless stated):
- ADD 0xFFFFFFFF + 0x00000001, out_ready=1 -> after 2 cycles: out_sum=0x00000000, carry=1, zero=1, ovf=0, neg=0.
- SUB 0x80000000 - 0x00000001 -> out_sum=0x7FFFFFFF, carry=1, ovf=1, neg=0. ADD 0x7FFFFFFF + 1 -> 0x80000000, ovf=1, neg=1, carry=0.
- ADC 0x0000FFFF + 0x00000000, cin=1 -> 0x00010000 (carry crosses the segment boundary at bit 16). SBC 5 - 3, cin=0 -> 0x00000001, carry=1.
- Back-to-back stream of 8 ADDs with out_ready=1 -> 8 results on 8 consecutive cycles, in order. Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable, no loss or duplication.
- Drive rst_n low for 1 cycle with 2 operations in flight -> out_valid=0 immediately (asynchronous). No results appear after release; the first new operation emerges 2 cycles after acceptance.
- Parameter sweep WIDTH=64/STAGES=4 and WIDTH=8/STAGES=1 with 1000 random operations -> every result and flag matches the reference model; latency equals STAGES.
